// File: rtl/picmicro_pc_stack.sv
// picmicro_pc_stack: parametrised program counter with PCLATH and a
// circular hardware return stack for the picmicro core family.
// Optional build macro PC_STACK_ERR_RESET_EN: when defined, a push into a
// full stack or a pop from an empty stack is suppressed and a one-cycle
// stack_err_rst_req pulse is raised; when undefined the stack wraps and
// stack_err_rst_req is tied low.
module picmicro_pc_stack #(
  parameter int PC_WIDTH     = 13,
  parameter int J_WIDTH      = 11,
  parameter int STACK_DEPTH  = 8,
  parameter int RESET_VECTOR = 0,
  parameter int INT_VECTOR   = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           pc_incr_en,
  input  logic                           pc_j_en,
  input  logic                           pc_j_and_push_en,
  input  logic                           pc_j_by_pop_en,
  input  logic                           int_vector_en,
  input  logic [J_WIDTH-1:0]             pc_j_addr,
  input  logic                           pclath_wr_en,
  input  logic [7:0]                     pclath_in,
  input  logic                           pcl_wr_en,
  input  logic [7:0]                     pcl_in,
  input  logic                           stack_err_clr,
  output logic [PC_WIDTH-1:0]            pc_out,
  output logic [7:0]                     pclath_out,
  output logic [$clog2(STACK_DEPTH):0]   stack_count,
  output logic                           stack_overflow,
  output logic                           stack_underflow,
  output logic                           stack_err_rst_req
);

  localparam int PL_W  = PC_WIDTH - 8;
  localparam int PTR_W = $clog2(STACK_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PC_WIDTH-1:0] pc_q;
  logic [PC_WIDTH-1:0] pc_next;
  logic [PL_W-1:0]     pclath_q;
  logic [PC_WIDTH-1:0] stack_mem [STACK_DEPTH];
  logic [PTR_W-1:0]    wp_q;
  logic [PTR_W-1:0]    wp_dec;
  logic [CNT_W-1:0]    count_q;
  logic                overflow_q;
  logic                underflow_q;

  logic [PC_WIDTH-1:0] pc_plus1;
  logic [PC_WIDTH-1:0] jump_target;
  logic [PC_WIDTH-1:0] pcl_target;
  logic [PC_WIDTH-1:0] top_of_stack;
  logic [PC_WIDTH-1:0] push_data;

  logic stack_full;
  logic stack_empty;
  logic do_pop;
  logic do_int;
  logic do_call;
  logic do_push;
  logic push_blocked;
  logic pop_blocked;
  logic overflow_set;
  logic underflow_set;

  // Only the low PL_W bits of pclath_in are architecturally stored.
  logic unused_pclath_in;
  assign unused_pclath_in = ^pclath_in;

  assign pc_plus1     = pc_q + PC_WIDTH'(1);
  assign jump_target  = {pclath_q[PL_W-1:J_WIDTH-8], pc_j_addr};
  assign pcl_target   = {pclath_q, pcl_in};
  assign wp_dec       = wp_q - PTR_W'(1);
  assign top_of_stack = stack_mem[wp_dec];

  assign stack_full  = (count_q == CNT_W'(STACK_DEPTH));
  assign stack_empty = (count_q == '0);

  // A pop outranks both push sources, so a coincident push is dropped
  // entirely and cannot raise an overflow.
  assign do_pop    = pc_j_by_pop_en;
  assign do_int    = !do_pop && int_vector_en;
  assign do_call   = !do_pop && !int_vector_en && pc_j_and_push_en;
  assign do_push   = do_int || do_call;
  assign push_data = do_int ? pc_q : pc_plus1;

  assign overflow_set  = do_push && stack_full;
  assign underflow_set = do_pop && stack_empty;

`ifdef PC_STACK_ERR_RESET_EN
  assign push_blocked = overflow_set;
  assign pop_blocked  = underflow_set;
`else
  assign push_blocked = 1'b0;
  assign pop_blocked  = 1'b0;
`endif

  // Select the next PC by fixed priority: pop, interrupt, call, goto, PCL, increment.
  always_comb begin
    pc_next = pc_q;
    if (do_pop) begin
      if (!pop_blocked) begin
        pc_next = top_of_stack;
      end
    end else if (do_int) begin
      if (!push_blocked) begin
        pc_next = PC_WIDTH'(INT_VECTOR);
      end
    end else if (do_call) begin
      if (!push_blocked) begin
        pc_next = jump_target;
      end
    end else if (pc_j_en) begin
      pc_next = jump_target;
    end else if (pcl_wr_en) begin
      pc_next = pcl_target;
    end else if (pc_incr_en) begin
      pc_next = pc_plus1;
    end
  end

  // Program counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= PC_WIDTH'(RESET_VECTOR);
    end else begin
      pc_q <= pc_next;
    end
  end

  // PCLATH register, written independently of the PC priority chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pclath_q <= '0;
    end else if (pclath_wr_en) begin
      pclath_q <= pclath_in[PL_W-1:0];
    end
  end

  // Return stack storage, write pointer and saturating occupancy count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STACK_DEPTH; i++) begin
        stack_mem[i] <= '0;
      end
      wp_q    <= '0;
      count_q <= '0;
    end else if (do_pop) begin
      if (!pop_blocked) begin
        wp_q <= wp_dec;
        if (!stack_empty) begin
          count_q <= count_q - CNT_W'(1);
        end
      end
    end else if (do_push) begin
      if (!push_blocked) begin
        stack_mem[wp_q] <= push_data;
        wp_q            <= wp_q + PTR_W'(1);
        if (!stack_full) begin
          count_q <= count_q + CNT_W'(1);
        end
      end
    end
  end

  // Sticky error flags; a new error in the same cycle beats a clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (overflow_set) begin
        overflow_q <= 1'b1;
      end else if (stack_err_clr) begin
        overflow_q <= 1'b0;
      end
      if (underflow_set) begin
        underflow_q <= 1'b1;
      end else if (stack_err_clr) begin
        underflow_q <= 1'b0;
      end
    end
  end

`ifdef PC_STACK_ERR_RESET_EN
  logic rst_req_q;

  // One-cycle reset request following each suppressed stack operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_req_q <= 1'b0;
    end else begin
      rst_req_q <= push_blocked || pop_blocked;
    end
  end

  assign stack_err_rst_req = rst_req_q;
`else
  assign stack_err_rst_req = 1'b0;
`endif

  assign pc_out          = pc_q;
  assign pclath_out      = 8'(pclath_q);
  assign stack_count     = count_q;
  assign stack_overflow  = overflow_q;
  assign stack_underflow = underflow_q;

endmodule

// File: tb/tb_picmicro_pc_stack.sv
// tb_picmicro_pc_stack: directed and randomized checks of picmicro_pc_stack
// against a behavioural model of the PC / PCLATH / return-stack rules.
module tb_picmicro_pc_stack;

  localparam int PC_WIDTH     = 13;
  localparam int J_WIDTH      = 11;
  localparam int STACK_DEPTH  = 8;
  localparam int RESET_VECTOR = 0;
  localparam int INT_VECTOR   = 4;
  localparam int PL_W         = PC_WIDTH - 8;
  localparam int CNT_W        = $clog2(STACK_DEPTH) + 1;
  localparam int PC_MOD       = 1 << PC_WIDTH;
`ifdef PC_STACK_ERR_RESET_EN
  localparam bit ERR_MODE = 1'b1;
`else
  localparam bit ERR_MODE = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst_n = 1'b1;
  logic                pc_incr_en = 1'b0;
  logic                pc_j_en = 1'b0;
  logic                pc_j_and_push_en = 1'b0;
  logic                pc_j_by_pop_en = 1'b0;
  logic                int_vector_en = 1'b0;
  logic [J_WIDTH-1:0]  pc_j_addr = '0;
  logic                pclath_wr_en = 1'b0;
  logic [7:0]          pclath_in = '0;
  logic                pcl_wr_en = 1'b0;
  logic [7:0]          pcl_in = '0;
  logic                stack_err_clr = 1'b0;
  logic [PC_WIDTH-1:0] pc_out;
  logic [7:0]          pclath_out;
  logic [CNT_W-1:0]    stack_count;
  logic                stack_overflow;
  logic                stack_underflow;
  logic                stack_err_rst_req;

  // Reference model state
  int m_pc;
  int m_pclath;
  int m_mem [STACK_DEPTH];
  int m_wp;
  int m_cnt;
  bit m_ovf;
  bit m_unf;
  bit m_req;

  int checks = 0;
  int errors = 0;

  picmicro_pc_stack #(
    .PC_WIDTH(PC_WIDTH), .J_WIDTH(J_WIDTH), .STACK_DEPTH(STACK_DEPTH),
    .RESET_VECTOR(RESET_VECTOR), .INT_VECTOR(INT_VECTOR)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .pc_incr_en(pc_incr_en), .pc_j_en(pc_j_en),
    .pc_j_and_push_en(pc_j_and_push_en), .pc_j_by_pop_en(pc_j_by_pop_en),
    .int_vector_en(int_vector_en), .pc_j_addr(pc_j_addr),
    .pclath_wr_en(pclath_wr_en), .pclath_in(pclath_in),
    .pcl_wr_en(pcl_wr_en), .pcl_in(pcl_in), .stack_err_clr(stack_err_clr),
    .pc_out(pc_out), .pclath_out(pclath_out), .stack_count(stack_count),
    .stack_overflow(stack_overflow), .stack_underflow(stack_underflow),
    .stack_err_rst_req(stack_err_rst_req)
  );

  // Free-running core clock
  always #5 clk = ~clk;

  task automatic modelReset();
    m_pc     = RESET_VECTOR;
    m_pclath = 0;
    for (int i = 0; i < STACK_DEPTH; i++) m_mem[i] = 0;
    m_wp  = 0;
    m_cnt = 0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
    m_req = 1'b0;
  endtask

  task automatic clearInputs();
    pc_incr_en       = 1'b0;
    pc_j_en          = 1'b0;
    pc_j_and_push_en = 1'b0;
    pc_j_by_pop_en   = 1'b0;
    int_vector_en    = 1'b0;
    pclath_wr_en     = 1'b0;
    pcl_wr_en        = 1'b0;
    stack_err_clr    = 1'b0;
  endtask

  // Advance the model by one edge from the driven inputs, then clock the DUT.
  task automatic applyStimulus();
    bit pop, intv, call, push, full, empty, blk_push, blk_pop;
    int n_pc, jt, pclt, tos;
    pop      = pc_j_by_pop_en;
    intv     = !pop && int_vector_en;
    call     = !pop && !intv && pc_j_and_push_en;
    push     = intv || call;
    full     = (m_cnt == STACK_DEPTH);
    empty    = (m_cnt == 0);
    blk_push = ERR_MODE && push && full;
    blk_pop  = ERR_MODE && pop && empty;
    jt       = ((m_pclath >> (J_WIDTH - 8)) << J_WIDTH) + int'(pc_j_addr);
    pclt     = m_pclath * 256 + int'(pcl_in);
    tos      = (m_wp + STACK_DEPTH - 1) % STACK_DEPTH;
    n_pc     = m_pc;
    if (pop) begin
      if (!blk_pop) n_pc = m_mem[tos];
    end else if (intv) begin
      if (!blk_push) n_pc = INT_VECTOR;
    end else if (call) begin
      if (!blk_push) n_pc = jt;
    end else if (pc_j_en) begin
      n_pc = jt;
    end else if (pcl_wr_en) begin
      n_pc = pclt;
    end else if (pc_incr_en) begin
      n_pc = (m_pc + 1) % PC_MOD;
    end
    if (pop && !blk_pop) begin
      m_wp = tos;
      if (m_cnt > 0) m_cnt = m_cnt - 1;
    end
    if (push && !blk_push) begin
      m_mem[m_wp] = intv ? m_pc : (m_pc + 1) % PC_MOD;
      m_wp = (m_wp + 1) % STACK_DEPTH;
      if (m_cnt < STACK_DEPTH) m_cnt = m_cnt + 1;
    end
    m_ovf = (push && full) ? 1'b1 : (stack_err_clr ? 1'b0 : m_ovf);
    m_unf = (pop && empty) ? 1'b1 : (stack_err_clr ? 1'b0 : m_unf);
    m_req = blk_push || blk_pop;
    if (pclath_wr_en) m_pclath = int'(pclath_in) % (1 << PL_W);
    m_pc = n_pc;
    @(posedge clk);
    #1;
    clearInputs();
  endtask

  // Compare every DUT output against the model.
  task automatic checkOutput(input string tag);
    checks = checks + 6;
    assert (pc_out === m_pc[PC_WIDTH-1:0])
      else begin errors++; $error("[TB] FAIL %s pc_out got %0h expected %0h", tag, pc_out, m_pc[PC_WIDTH-1:0]); end
    assert (pclath_out === m_pclath[7:0])
      else begin errors++; $error("[TB] FAIL %s pclath_out got %0h expected %0h", tag, pclath_out, m_pclath[7:0]); end
    assert (stack_count === m_cnt[CNT_W-1:0])
      else begin errors++; $error("[TB] FAIL %s stack_count got %0d expected %0d", tag, stack_count, m_cnt); end
    assert (stack_overflow === m_ovf)
      else begin errors++; $error("[TB] FAIL %s stack_overflow got %0b expected %0b", tag, stack_overflow, m_ovf); end
    assert (stack_underflow === m_unf)
      else begin errors++; $error("[TB] FAIL %s stack_underflow got %0b expected %0b", tag, stack_underflow, m_unf); end
    assert (stack_err_rst_req === m_req)
      else begin errors++; $error("[TB] FAIL %s stack_err_rst_req got %0b expected %0b", tag, stack_err_rst_req, m_req); end
  endtask

  // Compare one observed value against a fixed value from the worked examples.
  task automatic checkValue(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected)
      else begin errors++; $error("[TB] FAIL %s got %0h expected %0h", tag, observed, expected); end
  endtask

  task automatic asyncReset(input string tag);
    #2;
    rst_n = 1'b0;
    clearInputs();
    #1;
    modelReset();
    checkOutput(tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    $display("[TB] start");
    modelReset();
    asyncReset("reset");
    checkValue("reset_pc", int'(pc_out), RESET_VECTOR);
    checkValue("reset_count", int'(stack_count), 0);

    // Increment and GOTO with PCLATH upper bits
    for (int i = 0; i < 3; i++) begin
      pc_incr_en = 1'b1;
      applyStimulus();
      checkOutput("incr");
    end
    checkValue("incr3_pc", int'(pc_out), 3);
    pclath_wr_en = 1'b1; pclath_in = 8'h18;
    applyStimulus();
    checkOutput("pclath_wr");
    pc_j_en = 1'b1; pc_j_addr = 11'h123;
    applyStimulus();
    checkOutput("goto");
    checkValue("goto_pc", int'(pc_out), 'h1923);

    // CALL then RETURN
    pclath_wr_en = 1'b1; pclath_in = 8'h00;
    applyStimulus();
    pcl_wr_en = 1'b1; pcl_in = 8'h50;
    applyStimulus();
    checkOutput("pcl_50");
    pc_j_and_push_en = 1'b1; pc_j_addr = 11'h200;
    applyStimulus();
    checkOutput("call");
    checkValue("call_pc", int'(pc_out), 'h200);
    checkValue("call_count", int'(stack_count), 1);
    pc_j_by_pop_en = 1'b1;
    applyStimulus();
    checkOutput("return");
    checkValue("return_pc", int'(pc_out), 'h51);
    checkValue("return_count", int'(stack_count), 0);

    // Nine CALLs into an eight-deep stack, then drain it and one more
    pcl_wr_en = 1'b1; pcl_in = 8'h10;
    applyStimulus();
    for (int i = 0; i < 9; i++) begin
      pc_j_and_push_en = 1'b1; pc_j_addr = J_WIDTH'(16 + i + 1);
      applyStimulus();
      checkOutput("call_fill");
    end
    checkValue("fill_count", int'(stack_count), 8);
    checkValue("fill_overflow", int'(stack_overflow), 1);
    for (int i = 0; i < 9; i++) begin
      pc_j_by_pop_en = 1'b1;
      applyStimulus();
      checkOutput("return_drain");
`ifndef PC_STACK_ERR_RESET_EN
      if (i == 0) checkValue("drain_first_pc", int'(pc_out), 'h19);
      if (i == 8) checkValue("drain_wrapped_pc", int'(pc_out), 'h19);
`endif
    end
    checkValue("empty_pop_underflow", int'(stack_underflow), 1);
    checkValue("empty_pop_count", int'(stack_count), 0);

    // Error flag clear, then set and clear together
    stack_err_clr = 1'b1;
    applyStimulus();
    checkOutput("err_clr");
    checkValue("clr_underflow", int'(stack_underflow), 0);
    pc_j_by_pop_en = 1'b1; stack_err_clr = 1'b1;
    applyStimulus();
    checkOutput("set_and_clr");
    checkValue("set_wins_underflow", int'(stack_underflow), 1);

    // Interrupt vector with a coincident increment, then PCL jump with old PCLATH
    stack_err_clr = 1'b1;
    applyStimulus();
    pclath_wr_en = 1'b1; pclath_in = 8'h01;
    applyStimulus();
    pcl_wr_en = 1'b1; pcl_in = 8'h23;
    applyStimulus();
    checkOutput("pc_123");
    int_vector_en = 1'b1; pc_incr_en = 1'b1;
    applyStimulus();
    checkOutput("int_vector");
`ifndef PC_STACK_ERR_RESET_EN
    checkValue("int_pc", int'(pc_out), INT_VECTOR);
`endif
    pclath_wr_en = 1'b1; pclath_in = 8'h02;
    applyStimulus();
    pcl_wr_en = 1'b1; pcl_in = 8'h55; pclath_wr_en = 1'b1; pclath_in = 8'h1F;
    applyStimulus();
    checkOutput("pcl_old_pclath");
    checkValue("pcl_pc", int'(pc_out), 'h255);
    pc_j_by_pop_en = 1'b1;
    applyStimulus();
    checkOutput("int_return");
`ifndef PC_STACK_ERR_RESET_EN
    checkValue("int_return_pc", int'(pc_out), 'h123);
`endif

    // Reset in the middle of a call sequence
    for (int i = 0; i < 3; i++) begin
      pc_j_and_push_en = 1'b1; pc_j_addr = J_WIDTH'($urandom);
      applyStimulus();
    end
    checkOutput("pre_mid_reset");
    asyncReset("mid_reset");

    // Randomized operation mix, including coincident strobes and wrap cases
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        asyncReset("rand_reset");
      end else begin
        pc_j_by_pop_en   = ($urandom_range(0, 99) < 18);
        int_vector_en    = ($urandom_range(0, 99) < 8);
        pc_j_and_push_en = ($urandom_range(0, 99) < 22);
        pc_j_en          = ($urandom_range(0, 99) < 12);
        pcl_wr_en        = ($urandom_range(0, 99) < 12);
        pc_incr_en       = ($urandom_range(0, 99) < 60);
        pclath_wr_en     = ($urandom_range(0, 99) < 20);
        stack_err_clr    = ($urandom_range(0, 99) < 10);
        pc_j_addr        = J_WIDTH'($urandom);
        pclath_in        = 8'($urandom);
        pcl_in           = 8'($urandom);
        applyStimulus();
        checkOutput("random");
      end
    end

    // PC wrap from all-ones to zero
    pclath_wr_en = 1'b1; pclath_in = 8'hFF;
    applyStimulus();
    pcl_wr_en = 1'b1; pcl_in = 8'hFF;
    applyStimulus();
    pc_incr_en = 1'b1;
    applyStimulus();
    checkOutput("pc_wrap");
    checkValue("pc_wrap_zero", int'(pc_out), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
